// File: rtl/c64_bus_arbiter.sv
// c64_bus_arbiter
// Shares the single system RAM bus between the 6502 core and the VIC fetcher
// with C64-style two-phase interleaving. Phase A slots always belong to VIC;
// phase B slots belong to the CPU unless VIC is stealing them for badline
// fetches. BA drops BA_LEAD CPU slots ahead of AEC so that in-flight CPU
// writes can complete before the bus is taken away.
//
// Optional build macro: ARB_STEAL_COUNT_EN
//   defined   -> steal_count counts stolen phase-B slots (saturating)
//   undefined -> steal_count is tied to zero, no counter flops
module c64_bus_arbiter #(
    parameter int BA_LEAD = 3,
    parameter int AW      = 16,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_ab,
    input  logic [DW-1:0] cpu_do,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_di,
    output logic          cpu_rdy,
    input  logic [AW-1:0] vic_ab,
    input  logic          vic_steal_req,
    output logic [DW-1:0] vic_di,
    output logic          vic_strobe,
    output logic          vic_ba,
    output logic          aec,
    output logic          phi2,
    output logic [AW-1:0] mem_ab,
    output logic [DW-1:0] mem_do,
    output logic          mem_we,
    input  logic [DW-1:0] mem_di,
    output logic [15:0]   steal_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_STEAL = 2'd2
    } state_t;

    // Lead counter is 3 bits wide, enough for the 1..7 BA_LEAD range.
    localparam logic [2:0] LEAD_LOAD = 3'(BA_LEAD - 1);

    logic        phase_r;      // 0 = phase A, 1 = phase B
    state_t      state_r;
    logic [2:0]  cnt_r;
    logic        ba_r;
    logic        aec_r;
    logic        vic_slot_s;   // current slot is granted to VIC
    logic [DW-1:0] cpu_di_r;
    logic [DW-1:0] vic_di_r;
    logic        vic_strobe_r;

    // Slot ownership: every phase A, plus phase B while AEC is low.
    always_comb begin
        vic_slot_s = 1'b1;
        if (phase_r && aec_r) begin
            vic_slot_s = 1'b0;
        end else begin
            vic_slot_s = 1'b1;
        end
    end

    // Bus mux; VIC never writes, so mem_we follows the CPU only in its slots.
    always_comb begin
        mem_ab = vic_ab;
        mem_we = 1'b0;
        if (vic_slot_s) begin
            mem_ab = vic_ab;
            mem_we = 1'b0;
        end else begin
            mem_ab = cpu_ab;
            mem_we = cpu_we;
        end
    end

    assign mem_do      = cpu_do;
    assign phi2        = phase_r;
    assign vic_ba      = ba_r;
    assign cpu_rdy     = ba_r;
    assign aec         = aec_r;
    assign cpu_di      = cpu_di_r;
    assign vic_di      = vic_di_r;
    assign vic_strobe  = vic_strobe_r;

    // Phase register: alternates A/B every clock, first slot after reset is A.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= ~phase_r;
        end
    end

    // Steal FSM, advanced only at the edge ending a phase-B slot; BA/AEC registered with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            ba_r    <= 1'b1;
            aec_r   <= 1'b1;
        end else if (phase_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (vic_steal_req) begin
                        state_r <= ST_LEAD;
                        cnt_r   <= LEAD_LOAD;
                        ba_r    <= 1'b0;
                        aec_r   <= 1'b1;
                    end
                end
                ST_LEAD: begin
                    if (!vic_steal_req) begin
                        state_r <= ST_IDLE;
                        ba_r    <= 1'b1;
                        aec_r   <= 1'b1;
                    end else if (cnt_r == 3'd0) begin
                        state_r <= ST_STEAL;
                        ba_r    <= 1'b0;
                        aec_r   <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r - 3'd1;
                    end
                end
                ST_STEAL: begin
                    if (!vic_steal_req) begin
                        state_r <= ST_IDLE;
                        ba_r    <= 1'b1;
                        aec_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                    ba_r    <= 1'b1;
                    aec_r   <= 1'b1;
                end
            endcase
        end
    end

    // Read-data capture at the end of each slot into the owner's register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_di_r     <= '0;
            vic_di_r     <= '0;
            vic_strobe_r <= 1'b0;
        end else if (vic_slot_s) begin
            vic_di_r     <= mem_di;
            vic_strobe_r <= 1'b1;
        end else begin
            vic_strobe_r <= 1'b0;
            if (!cpu_we) begin
                cpu_di_r <= mem_di;
            end
        end
    end

`ifdef ARB_STEAL_COUNT_EN
    logic [15:0] steal_cnt_r;

    // Saturating count of phase-B slots taken from the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            steal_cnt_r <= 16'h0000;
        end else if (phase_r && !aec_r && (steal_cnt_r != 16'hFFFF)) begin
            steal_cnt_r <= steal_cnt_r + 16'h0001;
        end
    end

    assign steal_count = steal_cnt_r;
`else
    assign steal_count = 16'h0000;
`endif

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Self-checking bench for c64_bus_arbiter. A reference model tracks, per
// slot, how many consecutive phase-B slots have ended with a steal request
// and derives bus ownership and handshakes from that run length.
module tb_c64_bus_arbiter;

    localparam int BA_LEAD = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic [15:0] vic_ab;
    logic        vic_steal_req;
    logic [7:0]  vic_di;
    logic        vic_strobe;
    logic        vic_ba;
    logic        aec;
    logic        phi2;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic [7:0]  mem_di;
    logic [15:0] steal_count;

    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    int n_pass = 0;
    int n_fail = 0;

    // reference model state
    int         m_ph;
    int         m_k;
    int         m_steals;
    logic [7:0] e_cpu_di;
    logic [7:0] e_vic_di;
    logic       e_strobe;

    always #5 clk = ~clk;

    c64_bus_arbiter #(.BA_LEAD(BA_LEAD), .AW(16), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di),
        .cpu_rdy(cpu_rdy), .vic_ab(vic_ab), .vic_steal_req(vic_steal_req),
        .vic_di(vic_di), .vic_strobe(vic_strobe), .vic_ba(vic_ba), .aec(aec),
        .phi2(phi2), .mem_ab(mem_ab), .mem_do(mem_do), .mem_we(mem_we),
        .mem_di(mem_di), .steal_count(steal_count)
    );

    assign mem_di = ram[mem_ab];

    always @(posedge clk) begin
        if (mem_we) ram[mem_ab] <= mem_do;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_ph     = 0;
        m_k      = 0;
        m_steals = 0;
        e_cpu_di = 8'h00;
        e_vic_di = 8'h00;
        e_strobe = 1'b0;
    endtask

    function automatic logic [15:0] exp_steal_count();
`ifdef ARB_STEAL_COUNT_EN
        return (m_steals > 65535) ? 16'hFFFF : 16'(m_steals);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_phi2"},   32'(phi2),        32'd0);
        chk({tag, "_rdy"},    32'(cpu_rdy),     32'd1);
        chk({tag, "_ba"},     32'(vic_ba),      32'd1);
        chk({tag, "_aec"},    32'(aec),         32'd1);
        chk({tag, "_cpu_di"}, 32'(cpu_di),      32'd0);
        chk({tag, "_vic_di"}, 32'(vic_di),      32'd0);
        chk({tag, "_strobe"}, 32'(vic_strobe),  32'd0);
        chk({tag, "_scount"}, 32'(steal_count), 32'd0);
    endtask

    // One bus slot; entered just after a negedge, leaves at the next negedge.
    task automatic step(input logic req, input logic we, input logic [15:0] cab,
                        input logic [15:0] vab, input logic [7:0] cdo);
        logic        e_aec;
        logic        e_ba;
        logic        vslot;
        logic [15:0] e_ab;
        logic        e_we;
        logic [7:0]  rd;
        vic_steal_req = req;
        cpu_we        = we;
        cpu_ab        = cab;
        vic_ab        = vab;
        cpu_do        = cdo;
        #1;
        e_aec = (m_k <= BA_LEAD);
        e_ba  = (m_k == 0);
        vslot = (m_ph == 0) || !e_aec;
        e_ab  = vslot ? vab : cab;
        e_we  = !vslot && we;
        chk("phi2",   32'(phi2),    32'(m_ph));
        chk("aec",    32'(aec),     32'(e_aec));
        chk("vic_ba", 32'(vic_ba),  32'(e_ba));
        chk("rdy",    32'(cpu_rdy), 32'(e_ba));
        chk("mem_ab", 32'(mem_ab),  32'(e_ab));
        chk("mem_we", 32'(mem_we),  32'(e_we));
        chk("mem_do", 32'(mem_do),  32'(cdo));
        rd = ref_mem[e_ab];
        @(posedge clk);
        if (vslot) begin
            e_vic_di = rd;
            e_strobe = 1'b1;
        end else begin
            e_strobe = 1'b0;
            if (!we) e_cpu_di = rd;
        end
        if (e_we) ref_mem[e_ab] = cdo;
        if (m_ph == 1) begin
            if (!e_aec) m_steals = m_steals + 1;
            if (req) begin
                if (m_k < 1000) m_k = m_k + 1;
            end else begin
                m_k = 0;
            end
        end
        m_ph = 1 - m_ph;
        #1;
        chk("cpu_di",      32'(cpu_di),      32'(e_cpu_di));
        chk("vic_di",      32'(vic_di),      32'(e_vic_di));
        chk("vic_strobe",  32'(vic_strobe),  32'(e_strobe));
        chk("steal_count", 32'(steal_count), 32'(exp_steal_count()));
        @(negedge clk);
    endtask

    task automatic random_steps(input int n);
        logic r;
        r = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) r = ~r;
            step(r, ($urandom_range(0, 3) == 0), 16'($urandom_range(0, 255)),
                 16'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        reset         = 1'b0;
        cpu_ab        = 16'h0000;
        cpu_do        = 8'h00;
        cpu_we        = 1'b0;
        vic_ab        = 16'h0000;
        vic_steal_req = 1'b0;
        for (int a = 0; a < 65536; a++) begin
            ram[a]     = 8'($urandom);
            ref_mem[a] = ram[a];
        end
        ram[16'h0014]     = 8'h5A;
        ref_mem[16'h0014] = 8'h5A;
        ram[16'h0020]     = 8'h00;
        ref_mem[16'h0020] = 8'h00;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        model_reset();

        // CPU read of 0x0014
        step(1'b0, 1'b0, 16'h0014, 16'h0000, 8'h00);
        step(1'b0, 1'b0, 16'h0014, 16'h0000, 8'h00);
        chk("cpu_read_5a", 32'(cpu_di), 32'h5A);
        step(1'b0, 1'b0, 16'h0014, 16'h0000, 8'h00);
        step(1'b0, 1'b0, 16'h0014, 16'h0000, 8'h00);

        // CPU write held
        for (int i = 0; i < 4; i++) step(1'b1 & 1'b0, 1'b1, 16'h0020, 16'h0100, 8'h14);
        chk("ram_0020_written", 32'(ram[16'h0020]), 32'h14);

        // Steal held for 40 phase-B slots, then released
        for (int i = 0; i < 80; i++) step(1'b1, 1'b0, 16'h0014, 16'($urandom), 8'h00);
        step(1'b0, 1'b0, 16'h0014, 16'h0200, 8'h00);
        step(1'b0, 1'b0, 16'h0014, 16'h0201, 8'h00);
`ifdef ARB_STEAL_COUNT_EN
        chk("steal_count_37", 32'(steal_count), 32'd37);
`else
        chk("steal_count_off", 32'(steal_count), 32'd0);
`endif
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0014, 16'h0300, 8'h00);

        // Steal request pulsed for one phase B: LEAD entered then aborted
        step(1'b1, 1'b0, 16'h0014, 16'h0400, 8'h00);
        step(1'b1, 1'b0, 16'h0014, 16'h0401, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0014, 16'h0402, 8'h00);

        random_steps(400);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0014, 16'h0000, 8'h00);

        // Async reset in the middle of an active steal
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 16'h0014, 16'($urandom), 8'h00);
        chk("in_steal_aec", 32'(aec), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 16'h0014, 16'h0000, 8'h00);
        step(1'b0, 1'b0, 16'h0014, 16'h0000, 8'h00);

        random_steps(300);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/c64_bus_arbiter.md
Name: c64_bus_arbiter

Overview:
- Time-multiplexes the single system RAM bus between the 6502 core and the VIC video fetcher, using C64-style two-phase interleaving.
- Phase A slots always belong to VIC. Phase B slots belong to the CPU unless VIC steals them for badline fetches.
- Generates phi2 plus BA/AEC/RDY-style handshakes.
- Sits between `_6502`, the VIC fetch unit and the RAM model.

Parameters:
- BA_LEAD, 3: number of CPU (phase B) slots between BA falling and AEC falling. Legal range 1..7.
- AW, 16: address width.
- DW, 8: data width.

Ports:
- clk  in  1  system clock; one bus slot per cycle.
- reset  in  1  asynchronous, active-low reset.
- cpu_ab  in  AW  CPU address.
- cpu_do  in  DW  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_di  out  DW  registered CPU read data.
- cpu_rdy  out  1  CPU ready (1 = run).
- vic_ab  in  AW  VIC fetch address.
- vic_steal_req  in  1  VIC requests phase-B slots.
- vic_di  out  DW  registered VIC read data.
- vic_strobe  out  1  one-cycle pulse: vic_di updated.
- vic_ba  out  1  bus available (0 = steal pending or active).
- aec  out  1  1 = CPU owns phase-B slots.
- phi2  out  1  0 during phase A, 1 during phase B.
- mem_ab  out  AW  RAM address.
- mem_do  out  DW  RAM write data.
- mem_we  out  1  RAM write enable; RAM writes at posedge.
- mem_di  in  DW  RAM read data; combinational from mem_ab.
- steal_count  out  16  stolen-slot counter (see Optional Feature).

Behaviour:
Reset (reset=0, async):
- Phase register = A; state = IDLE; lead counter = 0.
- phi2=0, cpu_rdy=1, vic_ba=1, aec=1, cpu_di=0, vic_di=0, vic_strobe=0, steal_count=0.
- Reset asserted mid-steal aborts immediately; the first slot after release is phase A.

Phase:
- Toggles every clk: A,B,A,B… phi2 is the phase register itself.

Bus mux (combinational from phase and state):
- Phase A: mem_ab=vic_ab, mem_we=0.
- Phase B with aec=1: mem_ab=cpu_ab, mem_do=cpu_do, mem_we=cpu_we.
- Phase B with aec=0: mem_ab=vic_ab, mem_we=0.
- mem_do = cpu_do at all times.

Capture (at the posedge ending a slot):
- VIC-granted slot: vic_di <= mem_di; vic_strobe=1 for the following cycle, else 0.
- CPU-granted slot with cpu_we=0: cpu_di <= mem_di.
- cpu_di otherwise holds. Capture latency is 1 cycle.

FSM (evaluated only at the posedge ending phase B):
- IDLE: vic_steal_req=1 → LEAD with cnt=BA_LEAD-1.
- LEAD:
  - vic_steal_req=0 → IDLE (abort; no slot stolen).
  - Else cnt==0 → STEAL.
  - Else cnt decrements.
- STEAL: vic_steal_req=0 → IDLE.

Outputs from registered state:
- vic_ba = cpu_rdy = (state==IDLE).
- aec = (state!=STEAL).

LEAD semantics:
- Exactly BA_LEAD CPU slots still go to the CPU, so in-flight writes complete.
- Reads in those slots are still performed and captured.

Exit and timing:
- On return to IDLE, rdy/ba/aec all equal 1 starting with the next phase-A cycle.
- vic_steal_req changes during phase A are ignored until the end of the next phase B.

Optional Feature:
- Macro ARB_STEAL_COUNT_EN.
- Defined:
  - steal_count increments at the end of every phase-B slot with aec=0.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined:
  - steal_count is tied to 16'h0000; no counter flops.

Test Plan:
- Reset released, RAM[0x0014]=0x5A, cpu_ab=0x0014, cpu_we=0, vic_ab=0x0000 → phi2 alternates 0,1; cpu_di=0x5A the cycle after the first phase B; cpu_rdy=vic_ba=aec=1.
- CPU write: cpu_ab=0x0020, cpu_do=0x14, cpu_we=1 held → RAM[0x0020]=0x14 written only at a phase-B posedge; mem_we=0 in every phase A.
- vic_steal_req=1 held, BA_LEAD=3 → vic_ba and cpu_rdy fall after the first phase B; 3 more CPU slots are granted; then aec=0. Phase-B vic_di captures RAM[vic_ab] with a vic_strobe pulse every cycle.
- vic_steal_req pulsed high for one phase B, then low → LEAD entered and aborted; aec never 0; vic_ba=0 for exactly 2 cycles.
- Steal active, drive reset=0 for one cycle → all outputs return to reset values asynchronously; the first slot after release is phase A with aec=1.
- ARB_STEAL_COUNT_EN defined, steal held for 40 phase-B slots with BA_LEAD=3 → steal_count=37 (0x0025). Macro undefined → steal_count=0.
